// File: rtl/i2c_reg_sequencer.sv
// -----------------------------------------------------------------------------
// i2c_reg_sequencer
//
// Turns one register-access request into the ordered command stream that the
// byte-level I2C master consumes. It returns read data and a completion/error
// status. If the master hangs, it pulses the master's reset.
//
// Ports
//   clk        in   system clock
//   reset      in   synchronous active-low reset
//   go         in   request pulse, sampled only while idle
//   rw         in   0 = register write, 1 = register read
//   dev_addr   in   7-bit slave address
//   reg_addr   in   register index
//   wdata      in   write payload
//   rdata      out  last byte read (updated only by a successful read)
//   busy       out  transaction in progress (including the done cycle)
//   done       out  one-cycle completion pulse
//   err        out  status of the last transaction
//   m_i2c_en, m_start, m_stop  out  command strobes to the master
//   m_tx_data  out  byte to transmit
//   m_ready    in   master able to accept a command
//   m_tx_done  in   master finished shifting a written byte
//   m_rx_data  in   master receive register
//   m_reset_n  out  active-low reset to the master
// -----------------------------------------------------------------------------
module i2c_reg_sequencer #(
    parameter int TIMEOUT    = 50000,
    parameter int RST_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       go,
    input  logic       rw,
    input  logic [6:0] dev_addr,
    input  logic [7:0] reg_addr,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic       m_i2c_en,
    output logic       m_start,
    output logic       m_stop,
    output logic [7:0] m_tx_data,
    input  logic       m_ready,
    input  logic       m_tx_done,
    input  logic [7:0] m_rx_data,
    output logic       m_reset_n
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam int RST_W = $clog2(RST_CYCLES + 1);

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE, S_RECOVER} state_t;

    typedef struct packed {
        logic       en;
        logic       start;
        logic       stop;
        logic [7:0] tx;
    } cmd_t;

    localparam cmd_t CMD_NOP   = '{en: 1'b0, start: 1'b0, stop: 1'b0, tx: 8'h00};
    localparam cmd_t CMD_START = '{en: 1'b1, start: 1'b1, stop: 1'b0, tx: 8'h00};
    localparam cmd_t CMD_READ  = '{en: 1'b1, start: 1'b1, stop: 1'b1, tx: 8'h00};
    localparam cmd_t CMD_STOP  = '{en: 1'b1, start: 1'b0, stop: 1'b1, tx: 8'h00};

    function automatic cmd_t wr_cmd(input logic [7:0] b);
        wr_cmd = '{en: 1'b1, start: 1'b0, stop: 1'b0, tx: b};
    endfunction

    // Command for a given step. The master has no repeated start, so a read
    // closes the register-pointer write with STOP and opens a fresh START.
    function automatic cmd_t step_cmd(input logic       r,
                                      input logic [2:0] step,
                                      input logic [6:0] dev,
                                      input logic [7:0] ra,
                                      input logic [7:0] wd);
        cmd_t c;
        c = CMD_NOP;
        if (!r) begin
            case (step)
                3'd0:    c = CMD_START;
                3'd1:    c = wr_cmd({dev, 1'b0});
                3'd2:    c = wr_cmd(ra);
                3'd3:    c = wr_cmd(wd);
                3'd4:    c = CMD_STOP;
                default: c = CMD_NOP;
            endcase
        end else begin
            case (step)
                3'd0:    c = CMD_START;
                3'd1:    c = wr_cmd({dev, 1'b0});
                3'd2:    c = wr_cmd(ra);
                3'd3:    c = CMD_STOP;
                3'd4:    c = CMD_START;
                3'd5:    c = wr_cmd({dev, 1'b1});
                3'd6:    c = CMD_READ;
                default: c = CMD_STOP;
            endcase
        end
        return c;
    endfunction

    state_t           state_q, state_d;
    logic [2:0]       step_q, step_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [RST_W-1:0] rcnt_q, rcnt_d;
    logic             rw_q, rw_d;
    logic [6:0]       dev_q, dev_d;
    logic [7:0]       reg_q, reg_d;
    logic [7:0]       wdata_q, wdata_d;
    logic [7:0]       rdata_q, rdata_d;
    logic             err_q, err_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             mrst_n_q, mrst_n_d;
    cmd_t             cmd_q, cmd_d;

    // The step that just completed; the outputs already show NOP by then.
    cmd_t       cur;
    logic       cur_is_write;
    logic       cur_is_read;
    logic [2:0] last_step;
    logic       timed_out;

    assign cur          = step_cmd(rw_q, step_q, dev_q, reg_q, wdata_q);
    assign cur_is_write = cur.en & ~cur.start & ~cur.stop;
    assign cur_is_read  = cur.en & cur.start & cur.stop;
    assign last_step    = rw_q ? 3'd7 : 3'd4;
    assign timed_out    = (cnt_q == CNT_W'(TIMEOUT - 1));

    always_comb begin
        // NOTE: every variable gets a default before any branch so that no
        // path leaves it unassigned, which would infer a latch.
        state_d  = state_q;
        step_d   = step_q;
        cnt_d    = cnt_q;
        rcnt_d   = rcnt_q;
        rw_d     = rw_q;
        dev_d    = dev_q;
        reg_d    = reg_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        mrst_n_d = 1'b1;
        cmd_d    = cmd_q;

        case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                cmd_d  = CMD_NOP;
                if (go) begin
                    rw_d    = rw;
                    dev_d   = dev_addr;
                    reg_d   = reg_addr;
                    wdata_d = wdata;
                    err_d   = 1'b0;
                    step_d  = 3'd0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    cmd_d   = step_cmd(rw, 3'd0, dev_addr, reg_addr, wdata);
                    state_d = S_ISSUE;
                end
            end

            S_ISSUE: begin
                cnt_d = cnt_q + 1'b1;
                if (!m_ready) begin
                    cmd_d   = CMD_NOP;
                    state_d = S_WAIT;
                end else if (timed_out) begin
                    cmd_d    = CMD_NOP;
                    err_d    = 1'b1;
                    rcnt_d   = '0;
                    mrst_n_d = 1'b0;
                    state_d  = S_RECOVER;
                end
            end

            S_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                // A completion in the timeout cycle still counts as a completion.
                if (m_ready) begin
                    cnt_d = '0;
                    if (cur_is_write && !m_tx_done) begin
                        // Byte not acknowledged: abandon the rest and close the bus.
                        err_d   = 1'b1;
                        step_d  = last_step;
                        cmd_d   = CMD_STOP;
                        state_d = S_ISSUE;
                    end else begin
                        if (cur_is_read) begin
                            rdata_d = m_rx_data;
                        end
                        if (step_q == last_step) begin
                            done_d  = 1'b1;
                            state_d = S_DONE;
                        end else begin
                            step_d  = step_q + 3'd1;
                            cmd_d   = step_cmd(rw_q, step_q + 3'd1, dev_q, reg_q, wdata_q);
                            state_d = S_ISSUE;
                        end
                    end
                end else if (timed_out) begin
                    err_d    = 1'b1;
                    rcnt_d   = '0;
                    mrst_n_d = 1'b0;
                    state_d  = S_RECOVER;
                end
            end

            S_RECOVER: begin
                rcnt_d   = rcnt_q + 1'b1;
                mrst_n_d = 1'b0;
                if (rcnt_q == RST_W'(RST_CYCLES - 1)) begin
                    mrst_n_d = 1'b1;
                    done_d   = 1'b1;
                    state_d  = S_DONE;
                end
            end

            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end

            default: begin
                busy_d  = 1'b0;
                cmd_d   = CMD_NOP;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so that every
        // flop samples the pre-edge values, independent of statement order.
        if (!reset) begin
            state_q  <= S_IDLE;
            step_q   <= '0;
            cnt_q    <= '0;
            rcnt_q   <= '0;
            rw_q     <= 1'b0;
            dev_q    <= '0;
            reg_q    <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            mrst_n_q <= 1'b1;
            cmd_q    <= CMD_NOP;
        end else begin
            state_q  <= state_d;
            step_q   <= step_d;
            cnt_q    <= cnt_d;
            rcnt_q   <= rcnt_d;
            rw_q     <= rw_d;
            dev_q    <= dev_d;
            reg_q    <= reg_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            mrst_n_q <= mrst_n_d;
            cmd_q    <= cmd_d;
        end
    end

    assign rdata     = rdata_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign m_i2c_en  = cmd_q.en;
    assign m_start   = cmd_q.start;
    assign m_stop    = cmd_q.stop;
    assign m_tx_data = cmd_q.tx;
    assign m_reset_n = mrst_n_q;

endmodule
